// File: rtl/pcie_bram_pkg.sv
// Shared constants and elaboration-time helpers for the PCIe block-RAM
// read pipe: read latency, parity lane count and a ceil(log2) helper.
package pcie_bram_pkg;

  localparam int MIN_ADDR_W = 9;
  localparam int MAX_ADDR_W = 14;
  localparam int MAX_WIDTH  = 144;

  // ceil(log2(n)); returns 0 for n <= 1.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = 1; v < n; v = v * 2) r++;
    return r;
  endfunction

  // Cycles from an accepted read to data at the pipe tail.
  function automatic int rd_lat(input int dob_reg);
    return 1 + ((dob_reg != 0) ? 1 : 0);
  endfunction

  // One parity bit per byte lane, the last lane possibly partial.
  function automatic int par_bits(input int width);
    return (width + 7) / 8;
  endfunction

endpackage

// File: rtl/pcie_bram_skid_fifo.sv
// Small register FIFO used as the output skid stage. The head output shows
// the oldest entry while the FIFO holds data and keeps the last popped word
// while it is empty, so the downstream data bus does not wander when idle.
// The producer guarantees no push into a full FIFO (credit-limited).
module pcie_bram_skid_fifo
  import pcie_bram_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 3
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              push,
  input  logic [WIDTH-1:0]                  push_data,
  input  logic                              pop,
  output logic [WIDTH-1:0]                  head,
  output logic [clog2(DEPTH + 1) - 1:0]     count
);

  localparam int PW = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);
  localparam int CW = clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] last_q;
  logic             do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop = pop && (cnt != '0);

  // Storage registers; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Pointers, occupancy count and last-popped word.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      last_q <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop) begin
        rd_ptr <= next_ptr(rd_ptr);
        last_q <= mem[rd_ptr];
      end
      case ({push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign head  = (cnt != '0) ? mem[rd_ptr] : last_q;
  assign count = cnt;

endmodule

// File: rtl/pcie_bram_rd_pipe_s6.sv
// Simple dual-port block-RAM buffer with a flow-controlled read stream.
// Optional per-byte even parity is enabled with `define PCIE_BRAM_PARITY_EN.
//
// Handshake: a read request is accepted on a cycle where ren_i & ren_rdy_o;
// ren_rdy_o is a credit (outstanding reads < RD_LAT+1) and does not depend
// on ren_i. A beat transfers on rvalid_o & rready_i; while rvalid_o is high
// and rready_i is low, rvalid_o and rdata_o hold. Data returns in request
// order, at the earliest RD_LAT cycles after acceptance.
module pcie_bram_rd_pipe_s6
  import pcie_bram_pkg::*;
#(
  parameter int WIDTH   = 64,
  parameter int ADDR_W  = 10,
  parameter int DOB_REG = 1
) (
  input  logic                                      user_clk_i,
  input  logic                                      reset_i,
  input  logic                                      wen_i,
  input  logic [ADDR_W-1:0]                         waddr_i,
  input  logic [WIDTH-1:0]                          wdata_i,
  input  logic                                      ren_i,
  input  logic [ADDR_W-1:0]                         raddr_i,
  output logic                                      ren_rdy_o,
  output logic                                      rvalid_o,
  output logic [WIDTH-1:0]                          rdata_o,
  input  logic                                      rready_i,
  output logic [clog2(rd_lat(DOB_REG) + 2) - 1:0]   occupancy_o
`ifdef PCIE_BRAM_PARITY_EN
  ,
  output logic                                      rperr_o,
  output logic                                      perr_sticky_o
`endif
);

  localparam int RD_LAT = rd_lat(DOB_REG);
  localparam int OCC_W  = clog2(RD_LAT + 2);
  localparam int DEPTH  = RD_LAT + 1;
`ifdef PCIE_BRAM_PARITY_EN
  localparam int PB     = par_bits(WIDTH);
  localparam int MEM_W  = WIDTH + PB;
  localparam int FIFO_W = WIDTH + 1;
`else
  localparam int MEM_W  = WIDTH;
  localparam int FIFO_W = WIDTH;
`endif

  // Reject unsupported geometries at elaboration time.
  if (WIDTH < 1 || WIDTH > MAX_WIDTH || ADDR_W < MIN_ADDR_W || ADDR_W > MAX_ADDR_W) begin : g_param_err
    $error("pcie_bram_rd_pipe_s6: WIDTH=%0d / ADDR_W=%0d out of range", WIDTH, ADDR_W);
  end

`ifdef PCIE_BRAM_PARITY_EN
  // Even parity per byte lane: each bit is the XOR of its lane.
  function automatic logic [PB-1:0] lane_parity(input logic [WIDTH-1:0] d);
    logic [PB-1:0] p;
    p = '0;
    for (int i = 0; i < WIDTH; i++) p[i / 8] = p[i / 8] ^ d[i];
    return p;
  endfunction
`endif

  logic [MEM_W-1:0]  mem [2**ADDR_W];
  logic [MEM_W-1:0]  wr_word;
  logic              accept;
  logic              xfer;
  logic              collision;
  logic [MEM_W-1:0]  tail_word;
  logic              tail_valid;
  logic [FIFO_W-1:0] fifo_in;
  logic [FIFO_W-1:0] fifo_head;
  logic [clog2(DEPTH + 1) - 1:0] fifo_cnt;
  logic [OCC_W-1:0]  occ_q;

`ifdef PCIE_BRAM_PARITY_EN
  assign wr_word = {lane_parity(wdata_i), wdata_i};
`else
  assign wr_word = wdata_i;
`endif

  assign ren_rdy_o = !reset_i && (occ_q < OCC_W'(RD_LAT + 1));
  assign accept    = ren_i && ren_rdy_o;
  assign rvalid_o  = (fifo_cnt != '0);
  assign xfer      = rvalid_o && rready_i;
  assign collision = wen_i && (waddr_i == raddr_i);

  // Write port; memory contents are never reset.
  always_ff @(posedge user_clk_i) begin
    if (wen_i) mem[waddr_i] <= wr_word;
  end

  if (DOB_REG != 0) begin : g_dob
    logic [MEM_W-1:0] dout_q;
    logic [MEM_W-1:0] byp_data_q;
    logic             byp_q;
    logic             v_q;

    // Synchronous RAM read plus the write-first bypass captured alongside it.
    always_ff @(posedge user_clk_i) begin
      dout_q     <= mem[raddr_i];
      byp_data_q <= wr_word;
      byp_q      <= collision;
    end

    // Valid flag travelling with the registered read.
    always_ff @(posedge user_clk_i) begin
      if (reset_i) v_q <= 1'b0;
      else         v_q <= accept;
    end

    assign tail_word  = byp_q ? byp_data_q : dout_q;
    assign tail_valid = v_q;
  end else begin : g_no_dob
    // Without the output register the skid registers capture the read directly.
    assign tail_word  = collision ? wr_word : mem[raddr_i];
    assign tail_valid = accept;
  end

`ifdef PCIE_BRAM_PARITY_EN
  assign fifo_in = {|(tail_word[MEM_W-1:WIDTH] ^ lane_parity(tail_word[WIDTH-1:0])),
                    tail_word[WIDTH-1:0]};
`else
  assign fifo_in = tail_word;
`endif

  pcie_bram_skid_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (DEPTH)
  ) u_skid (
    .clk       (user_clk_i),
    .reset     (reset_i),
    .push      (tail_valid),
    .push_data (fifo_in),
    .pop       (xfer),
    .head      (fifo_head),
    .count     (fifo_cnt)
  );

  assign rdata_o     = fifo_head[WIDTH-1:0];
  assign occupancy_o = occ_q;

  // Outstanding-read credit counter: +1 on accept, -1 on transfer.
  always_ff @(posedge user_clk_i) begin
    if (reset_i) begin
      occ_q <= '0;
    end else begin
      case ({accept, xfer})
        2'b10:   occ_q <= occ_q + 1'b1;
        2'b01:   occ_q <= occ_q - 1'b1;
        default: occ_q <= occ_q;
      endcase
    end
  end

`ifdef PCIE_BRAM_PARITY_EN
  assign rperr_o = rvalid_o && fifo_head[WIDTH];

  // Sticky parity error, cleared only by reset.
  always_ff @(posedge user_clk_i) begin
    if (reset_i)             perr_sticky_o <= 1'b0;
    else if (xfer && rperr_o) perr_sticky_o <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_pcie_bram_rd_pipe_s6.sv
// Bench for pcie_bram_rd_pipe_s6 (ADDR_W=9, WIDTH=64, DOB_REG=1): a
// queue-based reference of memory, credits and return timing checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_pcie_bram_rd_pipe_s6;

  localparam int WIDTH   = 64;
  localparam int ADDR_W  = 9;
  localparam int DOB_REG = 1;
  localparam int RD_LAT  = 2;
  localparam int NWORDS  = 512;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_i;
  logic              wen_i;
  logic [ADDR_W-1:0] waddr_i;
  logic [WIDTH-1:0]  wdata_i;
  logic              ren_i;
  logic [ADDR_W-1:0] raddr_i;
  logic              ren_rdy_o;
  logic              rvalid_o;
  logic [WIDTH-1:0]  rdata_o;
  logic              rready_i;
  logic [1:0]        occupancy_o;
`ifdef PCIE_BRAM_PARITY_EN
  logic              rperr_o;
  logic              perr_sticky_o;
`endif

  pcie_bram_rd_pipe_s6 #(
    .WIDTH   (WIDTH),
    .ADDR_W  (ADDR_W),
    .DOB_REG (DOB_REG)
  ) dut (
    .user_clk_i    (clk),
    .reset_i       (reset_i),
    .wen_i         (wen_i),
    .waddr_i       (waddr_i),
    .wdata_i       (wdata_i),
    .ren_i         (ren_i),
    .raddr_i       (raddr_i),
    .ren_rdy_o     (ren_rdy_o),
    .rvalid_o      (rvalid_o),
    .rdata_o       (rdata_o),
    .rready_i      (rready_i),
    .occupancy_o   (occupancy_o)
`ifdef PCIE_BRAM_PARITY_EN
    ,
    .rperr_o       (rperr_o),
    .perr_sticky_o (perr_sticky_o)
`endif
  );

  // ---------------- reference model ----------------
  int              tests = 0;
  int              fails = 0;
  int              cyc = 0;
  bit              armed = 1'b0;
  logic [WIDTH-1:0] exp_q[$];     // data of outstanding reads, in order
  int               rdy_q[$];     // earliest cycle each may appear
  logic [WIDTH-1:0] mdl_mem [NWORDS];
  int               mdl_occ = 0;
  logic [WIDTH-1:0] mdl_last = '0;
  logic [WIDTH-1:0] got_q[$];     // beats observed leaving the DUT

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance the model on each clock edge from the inputs of the ending cycle.
  always @(posedge clk) begin
    bit acc;
    bit xfr;
    if (reset_i) begin
      exp_q.delete();
      rdy_q.delete();
      mdl_occ  = 0;
      mdl_last = '0;
      armed    = 1'b1;
    end else begin
      xfr = (exp_q.size() > 0) && (rdy_q[0] <= cyc) && rready_i;
      acc = ren_i && (mdl_occ < RD_LAT + 1);
      if (xfr) begin
        mdl_last = exp_q.pop_front();
        void'(rdy_q.pop_front());
      end
      if (acc) begin
        exp_q.push_back((wen_i && waddr_i == raddr_i) ? wdata_i : mdl_mem[raddr_i]);
        rdy_q.push_back(cyc + RD_LAT);
      end
      mdl_occ = mdl_occ + int'(acc) - int'(xfr);
    end
    if (wen_i) mdl_mem[waddr_i] = wdata_i;
    cyc++;
  end

  // Compare DUT outputs with the model mid-cycle, and log transferred beats.
  always @(negedge clk) begin
    bit exp_valid;
    if (armed) begin
      exp_valid = (exp_q.size() > 0) && (rdy_q[0] <= cyc);
      check("ren_rdy", 64'(ren_rdy_o), 64'(!reset_i && (mdl_occ < RD_LAT + 1)));
      check("occupancy", 64'(occupancy_o), 64'(mdl_occ));
      check("rvalid", 64'(rvalid_o), 64'(exp_valid));
      check("rdata", rdata_o, exp_valid ? exp_q[0] : mdl_last);
`ifdef PCIE_BRAM_PARITY_EN
      check("perr_sticky", 64'(perr_sticky_o), 64'(0));
`endif
      if (!reset_i && rvalid_o && rready_i) got_q.push_back(rdata_o);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wen_i = 1'b0;
    ren_i = 1'b0;
  endtask

  task automatic wr(input int a, input logic [WIDTH-1:0] d);
    wen_i = 1'b1; waddr_i = ADDR_W'(a); wdata_i = d;
    tick();
    wen_i = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t0;
    int first_v;
    int acc_cnt;

    reset_i = 1'b1; wen_i = 1'b0; ren_i = 1'b0; rready_i = 1'b1;
    waddr_i = '0; raddr_i = '0; wdata_i = '0;
    tick(); tick();
    @(negedge clk);
    check("rdy_in_reset", 64'(ren_rdy_o), 64'(0));
    tick();
    reset_i = 1'b0;
    @(negedge clk);
    check("rst_rvalid", 64'(rvalid_o), 64'(0));
    check("rst_occ", 64'(occupancy_o), 64'(0));
    check("rst_rdata", rdata_o, 64'(0));
    check("rst_rdy_after", 64'(ren_rdy_o), 64'(1));

    // Initialise every word so any read has a defined expectation.
    for (int a = 0; a < NWORDS; a++) wr(a, {$urandom, $urandom});

    // Back-to-back reads of 0x11..0x18.
    for (int i = 0; i < 8; i++) wr(i, 64'(8'h11 + i));
    got_q.delete();
    t0 = -1; first_v = -1;
    for (int i = 0; i < 10; i++) begin
      ren_i = (i < 8); raddr_i = ADDR_W'(i);
      if (i == 0) t0 = cyc;
      @(negedge clk);
      if (rvalid_o && first_v < 0) first_v = cyc;
      tick();
    end
    ren_i = 1'b0;
    check("first_latency", 64'(first_v - t0), 64'(2));
    check("b2b_count", 64'(got_q.size()), 64'(8));
    for (int i = 0; i < 8 && i < got_q.size(); i++) check("b2b_data", got_q[i], 64'(8'h11 + i));

    // Stall: only three credits with rready low.
    got_q.delete();
    rready_i = 1'b0; acc_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      ren_i = 1'b1; raddr_i = ADDR_W'(i);
      @(negedge clk);
      if (ren_rdy_o) acc_cnt++;
      tick();
    end
    ren_i = 1'b0;
    @(negedge clk);
    check("stall_accepts", 64'(acc_cnt), 64'(3));
    check("stall_rdy", 64'(ren_rdy_o), 64'(0));
    check("stall_occ", 64'(occupancy_o), 64'(3));
    tick();
    rready_i = 1'b1;
    @(negedge clk);
    check("rdy_during_first_xfer", 64'(ren_rdy_o), 64'(0));
    tick();
    @(negedge clk);
    check("rdy_after_first_xfer", 64'(ren_rdy_o), 64'(1));
    repeat (4) tick();
    check("stall_count", 64'(got_q.size()), 64'(3));
    for (int i = 0; i < 3 && i < got_q.size(); i++) check("stall_data", got_q[i], 64'(8'h11 + i));

    // Collision: read before the write sees old data, same-cycle read sees new.
    got_q.delete();
    wr(5, 64'hAA);
    ren_i = 1'b1; raddr_i = 9'd5;
    tick();
    wen_i = 1'b1; waddr_i = 9'd5; wdata_i = 64'h55;
    tick();
    idle();
    repeat (4) tick();
    check("coll_count", 64'(got_q.size()), 64'(2));
    if (got_q.size() == 2) begin
      check("coll_before", got_q[0], 64'hAA);
      check("coll_same", got_q[1], 64'h55);
    end

    // Top address and address 0.
    got_q.delete();
    wr(511, 64'hDEAD_BEEF_0123_4567);
    wr(0, 64'h0F0F);
    ren_i = 1'b1; raddr_i = 9'd511; tick();
    raddr_i = 9'd0; tick();
    idle();
    repeat (4) tick();
    check("wrap_count", 64'(got_q.size()), 64'(2));
    if (got_q.size() == 2) begin
      check("addr_511", got_q[0], 64'hDEAD_BEEF_0123_4567);
      check("addr_0", got_q[1], 64'h0F0F);
    end

    // Reset with two reads in flight.
    got_q.delete();
    rready_i = 1'b0;
    ren_i = 1'b1; raddr_i = 9'd1; tick();
    raddr_i = 9'd2; tick();
    ren_i = 1'b0; reset_i = 1'b1; tick();
    reset_i = 1'b0;
    @(negedge clk);
    check("midrst_rvalid", 64'(rvalid_o), 64'(0));
    check("midrst_occ", 64'(occupancy_o), 64'(0));
    rready_i = 1'b1;
    repeat (4) tick();
    check("midrst_no_beat", 64'(got_q.size()), 64'(0));
    ren_i = 1'b1; raddr_i = 9'd3; tick();
    idle();
    repeat (4) tick();
    check("post_rst_count", 64'(got_q.size()), 64'(1));
    if (got_q.size() == 1) check("post_rst_data", got_q[0], 64'h14);

    // Random traffic with a narrow address window to provoke collisions.
    for (int n = 0; n < 3000; n++) begin
      wen_i    = ($urandom_range(0, 1) == 1);
      waddr_i  = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, 7));
      wdata_i  = {$urandom, $urandom};
      ren_i    = ($urandom_range(0, 9) < 7);
      raddr_i  = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, 7));
      rready_i = ($urandom_range(0, 3) != 0);
      reset_i  = ($urandom_range(0, 599) == 0);
      tick();
    end
    idle(); reset_i = 1'b0; rready_i = 1'b1;
    repeat (8) tick();
    @(negedge clk);
    check("drain_occ", 64'(occupancy_o), 64'(0));
    check("drain_rvalid", 64'(rvalid_o), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
